// File: rtl/motor_pwm_driver.sv
// H-bridge PWM driver for two motors with dead-time on reversal.
// Define MOTOR_PWM_RAMP_EN to ramp duty_eff toward the target by RAMP_STEP per PWM period.
module motor_pwm_driver #(
   parameter int unsigned PRESCALE    = 40,
   parameter int unsigned DEAD_CYCLES = 16,
   parameter int unsigned RAMP_STEP   = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_dir_a,
   input  logic [1:0] cmd_dir_b,
   input  logic [7:0] cmd_duty,
   output logic       motorA_d,
   output logic       motorA_i,
   output logic       motorB_d,
   output logic       motorB_i,
   output logic       period_tick,
   output logic       busy
);

   localparam int unsigned PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int unsigned DC_W = (DEAD_CYCLES > 1) ? $clog2(DEAD_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DEAD, BRAKE} state_t;

   state_t            state_a, state_a_nxt, state_b, state_b_nxt;
   logic [1:0]        dir_a, dir_a_nxt, dir_b, dir_b_nxt;
   logic [DC_W-1:0]   dead_a, dead_a_nxt, dead_b, dead_b_nxt;
   logic [PS_W-1:0]   prescaler, prescaler_nxt;
   logic [7:0]        pwm_cnt, pwm_cnt_nxt;
   logic [7:0]        duty_tgt, duty_tgt_nxt;
   logic [7:0]        duty_eff, duty_eff_nxt;
   logic              a_d_nxt, a_i_nxt, b_d_nxt, b_i_nxt;
   logic              tick_nxt, busy_nxt, ready_nxt;
   logic              presc_wrap, accept, pwm_nxt;

   // State a channel settles into once any dead-time has elapsed
   function automatic state_t pend_state(input logic [1:0] dir);
      case (dir)
         2'b00:   pend_state = IDLE;
         2'b11:   pend_state = BRAKE;
         default: pend_state = RUN;
      endcase
   endfunction

   function automatic state_t chan_next(input state_t st, input logic [1:0] cur,
                                        input logic [1:0] nd, input logic acc,
                                        input logic dead_done);
      chan_next = st;
      case (st)
         IDLE:  if (acc) chan_next = pend_state(nd);
         RUN:   if (acc && nd != cur) chan_next = (nd == 2'b00) ? IDLE : DEAD;
         BRAKE: if (acc && nd != 2'b11) chan_next = (nd == 2'b00) ? IDLE : DEAD;
         DEAD:  if (dead_done) chan_next = pend_state(cur);
         default: chan_next = IDLE;
      endcase
   endfunction

   function automatic logic [DC_W-1:0] dead_next(input state_t st, input state_t nxt,
                                                 input logic [DC_W-1:0] cnt);
      dead_next = cnt;
      if (st != DEAD && nxt == DEAD)
         dead_next = DC_W'(DEAD_CYCLES - 1);
      else if (st == DEAD && cnt != '0)
         dead_next = cnt - DC_W'(1);
   endfunction

   // Returns {d, i} for a channel; both high only in BRAKE
   function automatic logic [1:0] drive(input state_t st, input logic [1:0] dir, input logic pwm);
      drive = 2'b00;
      case (st)
         RUN: begin
            if (dir == 2'b01) drive = {pwm, 1'b0};
            else if (dir == 2'b10) drive = {1'b0, pwm};
         end
         BRAKE:   drive = 2'b11;
         default: drive = 2'b00;
      endcase
   endfunction

   // One ramp step toward t, saturating at t; 9-bit math avoids wrap
   function automatic logic [7:0] ramp(input logic [7:0] e, input logic [7:0] t);
      logic [8:0] e9, t9, s9;
      e9 = {1'b0, e};
      t9 = {1'b0, t};
      s9 = 9'(RAMP_STEP);
      if (e9 < t9)
         ramp = (t9 - e9 <= s9) ? t : 8'(e9 + s9);
      else
         ramp = (e9 - t9 <= s9) ? t : 8'(e9 - s9);
   endfunction

   always_ff @(posedge clk) begin
      if (reset) begin
         state_a     <= IDLE;
         state_b     <= IDLE;
         dir_a       <= 2'b00;
         dir_b       <= 2'b00;
         dead_a      <= '0;
         dead_b      <= '0;
         prescaler   <= '0;
         pwm_cnt     <= 8'd0;
         duty_tgt    <= 8'd0;
         duty_eff    <= 8'd0;
         motorA_d    <= 1'b0;
         motorA_i    <= 1'b0;
         motorB_d    <= 1'b0;
         motorB_i    <= 1'b0;
         period_tick <= 1'b0;
         busy        <= 1'b0;
         cmd_ready   <= 1'b1;
      end else begin
         state_a     <= state_a_nxt;
         state_b     <= state_b_nxt;
         dir_a       <= dir_a_nxt;
         dir_b       <= dir_b_nxt;
         dead_a      <= dead_a_nxt;
         dead_b      <= dead_b_nxt;
         prescaler   <= prescaler_nxt;
         pwm_cnt     <= pwm_cnt_nxt;
         duty_tgt    <= duty_tgt_nxt;
         duty_eff    <= duty_eff_nxt;
         motorA_d    <= a_d_nxt;
         motorA_i    <= a_i_nxt;
         motorB_d    <= b_d_nxt;
         motorB_i    <= b_i_nxt;
         period_tick <= tick_nxt;
         busy        <= busy_nxt;
         cmd_ready   <= ready_nxt;
      end
   end

   always_comb begin
      state_a_nxt   = state_a;
      state_b_nxt   = state_b;
      dir_a_nxt     = dir_a;
      dir_b_nxt     = dir_b;
      dead_a_nxt    = dead_a;
      dead_b_nxt    = dead_b;
      prescaler_nxt = prescaler + PS_W'(1);
      pwm_cnt_nxt   = pwm_cnt;
      duty_tgt_nxt  = duty_tgt;
      duty_eff_nxt  = duty_eff;
      tick_nxt      = 1'b0;

      // Timebase: prescaler then 0..254 PWM counter
      presc_wrap = (prescaler == PS_W'(PRESCALE - 1));
      if (presc_wrap) begin
         prescaler_nxt = '0;
         if (pwm_cnt == 8'd254) begin
            pwm_cnt_nxt = 8'd0;
            tick_nxt    = 1'b1;
         end else begin
            pwm_cnt_nxt = pwm_cnt + 8'd1;
         end
      end

      accept = cmd_valid && cmd_ready;
      if (accept) begin
         duty_tgt_nxt = cmd_duty;
         dir_a_nxt    = cmd_dir_a;
         dir_b_nxt    = cmd_dir_b;
      end

      state_a_nxt = chan_next(state_a, dir_a, cmd_dir_a, accept, dead_a == '0);
      state_b_nxt = chan_next(state_b, dir_b, cmd_dir_b, accept, dead_b == '0);
      dead_a_nxt  = dead_next(state_a, state_a_nxt, dead_a);
      dead_b_nxt  = dead_next(state_b, state_b_nxt, dead_b);

`ifdef MOTOR_PWM_RAMP_EN
      if ((state_a != IDLE && state_a_nxt == IDLE) || (state_a != DEAD && state_a_nxt == DEAD) ||
          (state_b != IDLE && state_b_nxt == IDLE) || (state_b != DEAD && state_b_nxt == DEAD))
         duty_eff_nxt = 8'd0;
      else if (tick_nxt)
         duty_eff_nxt = ramp(duty_eff, duty_tgt_nxt);
`else
      if (tick_nxt)
         duty_eff_nxt = duty_tgt_nxt;
`endif

      // Lines are registered from next-cycle state so they move with the state change
      pwm_nxt              = (pwm_cnt_nxt < duty_eff_nxt);
      {a_d_nxt, a_i_nxt}   = drive(state_a_nxt, dir_a_nxt, pwm_nxt);
      {b_d_nxt, b_i_nxt}   = drive(state_b_nxt, dir_b_nxt, pwm_nxt);

      busy_nxt  = (state_a_nxt == DEAD) || (state_b_nxt == DEAD);
      ready_nxt = !busy_nxt;
   end

endmodule

// File: tb/tb_motor_pwm_driver.sv
// Directed bench for motor_pwm_driver with PRESCALE=1, DEAD_CYCLES=4, RAMP_STEP=64.
module tb_motor_pwm_driver;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [1:0] cmd_dir_a;
   logic [1:0] cmd_dir_b;
   logic [7:0] cmd_duty;
   logic       motorA_d, motorA_i, motorB_d, motorB_i;
   logic       period_tick;
   logic       busy;

   int checks = 0;
   int errors = 0;
   int cnt_ad, cnt_ai, cnt_bd, cnt_bi, cnt_tick, cnt_both;

   motor_pwm_driver #(
      .PRESCALE   (1),
      .DEAD_CYCLES(4),
      .RAMP_STEP  (64)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cmd_valid  (cmd_valid),
      .cmd_ready  (cmd_ready),
      .cmd_dir_a  (cmd_dir_a),
      .cmd_dir_b  (cmd_dir_b),
      .cmd_duty   (cmd_duty),
      .motorA_d   (motorA_d),
      .motorA_i   (motorA_i),
      .motorB_d   (motorB_d),
      .motorB_i   (motorB_i),
      .period_tick(period_tick),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input logic [1:0] da, input logic [1:0] db, input logic [7:0] duty);
      cmd_valid = 1'b1;
      cmd_dir_a = da;
      cmd_dir_b = db;
      cmd_duty  = duty;
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Advance to the next period_tick, bounded
   task automatic wait_tick();
      int n = 0;
      @(negedge clk);
      while (period_tick !== 1'b1 && n < 600) begin
         @(negedge clk);
         n++;
      end
      check("wait_tick", int'(period_tick), 1);
   endtask

   task automatic measure(input int n);
      cnt_ad = 0; cnt_ai = 0; cnt_bd = 0; cnt_bi = 0; cnt_tick = 0; cnt_both = 0;
      for (int k = 0; k < n; k++) begin
         cnt_ad   += int'(motorA_d);
         cnt_ai   += int'(motorA_i);
         cnt_bd   += int'(motorB_d);
         cnt_bi   += int'(motorB_i);
         cnt_tick += int'(period_tick);
         cnt_both += int'((motorA_d & motorA_i) | (motorB_d & motorB_i));
         @(negedge clk);
      end
   endtask

   initial begin
      int nb, la;
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_dir_a = 2'b00;
      cmd_dir_b = 2'b00;
      cmd_duty  = 8'd0;
      repeat (3) @(negedge clk);
      check("rst_a_d", int'(motorA_d), 0);
      check("rst_a_i", int'(motorA_i), 0);
      check("rst_b_d", int'(motorB_d), 0);
      check("rst_b_i", int'(motorB_i), 0);
      check("rst_tick", int'(period_tick), 0);
      check("rst_busy", int'(busy), 0);
      check("rst_ready", int'(cmd_ready), 1);
      reset = 1'b0;
      @(negedge clk);

`ifdef MOTOR_PWM_RAMP_EN
      send_cmd(2'b01, 2'b00, 8'd200);
      wait_tick();
      measure(255); check("ramp_up_64", cnt_ad, 64);
      measure(255); check("ramp_up_128", cnt_ad, 128);
      measure(255); check("ramp_up_192", cnt_ad, 192);
      measure(255); check("ramp_up_200", cnt_ad, 200);
      send_cmd(2'b01, 2'b00, 8'd10);
      wait_tick();
      measure(255); check("ramp_dn_136", cnt_ad, 136);
      measure(255); check("ramp_dn_72", cnt_ad, 72);
      measure(255); check("ramp_dn_10", cnt_ad, 10);
      check("ramp_tick_period", int'(period_tick), 1);
`else
      // Forward on both motors at half duty
      send_cmd(2'b01, 2'b01, 8'd128);
      check("fwd_pre_tick_a_d", int'(motorA_d), 0);
      wait_tick();
      measure(255);
      check("fwd_a_d_high", cnt_ad, 128);
      check("fwd_b_d_high", cnt_bd, 128);
      check("fwd_a_i_high", cnt_ai, 0);
      check("fwd_b_i_high", cnt_bi, 0);
      check("fwd_ticks", cnt_tick, 1);
      check("fwd_tick_period", int'(period_tick), 1);

      // Reverse motor A: dead-time, ignored command during DEAD
      send_cmd(2'b10, 2'b01, 8'd128);
      check("rev_busy", int'(busy), 1);
      check("rev_ready", int'(cmd_ready), 0);
      nb = 0; la = 0;
      for (int k = 0; k < 10; k++) begin
         if (busy) begin
            nb++;
            la += int'(motorA_d) + int'(motorA_i);
         end
         if (k == 1) begin
            cmd_valid = 1'b1;
            cmd_dir_a = 2'b01;
            cmd_duty  = 8'd0;
         end else begin
            cmd_valid = 1'b0;
         end
         @(negedge clk);
      end
      cmd_dir_a = 2'b10;
      cmd_duty  = 8'd128;
      check("rev_dead_len", nb, 4);
      check("rev_dead_lines", la, 0);
      wait_tick();
      measure(255);
      check("rev_a_i_high", cnt_ai, 128);
      check("rev_a_d_high", cnt_ad, 0);
      check("rev_b_d_high", cnt_bd, 128);
      check("rev_no_shoot", cnt_both, 0);

      // Extreme duties
      send_cmd(2'b10, 2'b01, 8'd0);
      wait_tick();
      measure(255);
      check("duty0_a_i", cnt_ai, 0);
      check("duty0_b_d", cnt_bd, 0);
      send_cmd(2'b10, 2'b01, 8'd255);
      wait_tick();
      measure(765);
      check("duty255_a_i", cnt_ai, 765);
      check("duty255_b_d", cnt_bd, 765);
      check("duty255_a_d", cnt_ad, 0);
      check("duty255_ticks", cnt_tick, 3);

      // Stop, then brake from IDLE
      send_cmd(2'b00, 2'b00, 8'd255);
      check("stop_a_i", int'(motorA_i), 0);
      check("stop_b_d", int'(motorB_d), 0);
      check("stop_busy", int'(busy), 0);
      send_cmd(2'b11, 2'b00, 8'd255);
      check("brake_a_d", int'(motorA_d), 1);
      check("brake_a_i", int'(motorA_i), 1);
      check("brake_b_d", int'(motorB_d), 0);

      // Reset mid-DEAD
      send_cmd(2'b01, 2'b00, 8'd255);
      check("brk2fwd_busy", int'(busy), 1);
      check("brk2fwd_lines", int'(motorA_d) + int'(motorA_i), 0);
      reset = 1'b1;
      @(negedge clk);
      check("rstdead_busy", int'(busy), 0);
      check("rstdead_ready", int'(cmd_ready), 1);
      check("rstdead_lines", int'(motorA_d) + int'(motorA_i), 0);
      reset = 1'b0;
      send_cmd(2'b01, 2'b00, 8'd255);
      check("postrst_no_dead", int'(busy), 0);
      wait_tick();
      measure(255);
      check("postrst_a_d", cnt_ad, 255);

      // Reset while the line is high
      check("pre_rst_a_d", int'(motorA_d), 1);
      reset = 1'b1;
      @(negedge clk);
      check("rsthigh_a_d", int'(motorA_d), 0);
      check("rsthigh_ready", int'(cmd_ready), 1);
      check("rsthigh_tick", int'(period_tick), 0);
      reset = 1'b0;
`endif
      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
